// File: rtl/naive_bus_pkg.sv
// naive_bus_pkg: shared master ids and master count for the naive_bus arbiter.
package naive_bus_pkg;
    typedef enum logic {MST0 = 1'b0, MST1 = 1'b1} mst_id_t;
    localparam int NUM_MST = 2;
endpackage

// File: rtl/naive_bus.sv
// naive_bus: split read/write request-grant bus; rd_data follows an rd_gnt by one cycle.
interface naive_bus #(parameter int AW = 32, parameter int DW = 32);
    logic          rd_req;
    logic          rd_gnt;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          wr_req;
    logic          wr_gnt;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW/8-1:0] wr_be;
    modport master (output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
                    input  rd_gnt, rd_data, wr_gnt);
    modport slave  (input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
                    output rd_gnt, rd_data, wr_gnt);
endinterface

// File: rtl/naive_bus_arbiter2_rr_pick2.sv
// rr_pick2: two-way picker with its own round-robin pointer; with NAIVE_ARB_FIXED_PRIO_EN
// defined, master 0 always wins and no pointer exists.
module rr_pick2
    import naive_bus_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_MST-1:0] req,
    input  logic               en,
    output mst_id_t            sel,
    output mst_id_t            pri_nxt
);
`ifdef NAIVE_ARB_FIXED_PRIO_EN
    logic unused;
    assign unused  = clk ^ rst ^ en;
    assign sel     = req == 2'b10 ? MST1 : MST0;
    assign pri_nxt = MST0;
`else
    mst_id_t pri;
    assign sel     = &req ? pri : (req[1] ? MST1 : MST0);
    // the loser of a granted transfer is favoured next time
    assign pri_nxt = en ? (sel == MST0 ? MST1 : MST0) : pri;
    always_ff @(posedge clk) pri <= rst ? MST0 : pri_nxt;
`endif
endmodule

// File: rtl/naive_bus_arbiter2.sv
// naive_bus_arbiter2: two masters onto one naive_bus slave, independent read/write arbitration
// (round-robin, or fixed m0 priority with NAIVE_ARB_FIXED_PRIO_EN) and owner-routed read data.
module naive_bus_arbiter2
    import naive_bus_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic      clk,
    input  logic      rst,
    naive_bus.slave   m0,
    naive_bus.slave   m1,
    naive_bus.master  s
);
    logic [NUM_MST-1:0] rd_req, wr_req;
    mst_id_t rd_sel, wr_sel, rd_own, rd_pri_nxt, wr_pri_nxt;
    logic rd_own_v, unused_pri;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW/8-1:0] wr_be;
    assign rd_req = {m1.rd_req, m0.rd_req};
    assign wr_req = {m1.wr_req, m0.wr_req};
    rr_pick2 u_rd (.clk(clk), .rst(rst), .req(rd_req), .en(s.rd_req & s.rd_gnt),
                   .sel(rd_sel), .pri_nxt(rd_pri_nxt));
    rr_pick2 u_wr (.clk(clk), .rst(rst), .req(wr_req), .en(s.wr_req & s.wr_gnt),
                   .sel(wr_sel), .pri_nxt(wr_pri_nxt));
    assign unused_pri = rd_pri_nxt ^ wr_pri_nxt;
    // idle channels drive zeros rather than a stale master's fields
    assign rd_addr = !(|rd_req) ? '0 : (rd_sel == MST1 ? m1.rd_addr : m0.rd_addr);
    assign wr_addr = !(|wr_req) ? '0 : (wr_sel == MST1 ? m1.wr_addr : m0.wr_addr);
    assign wr_data = !(|wr_req) ? '0 : (wr_sel == MST1 ? m1.wr_data : m0.wr_data);
    assign wr_be   = !(|wr_req) ? '0 : (wr_sel == MST1 ? m1.wr_be   : m0.wr_be);
    assign s.rd_req  = |rd_req;
    assign s.wr_req  = |wr_req;
    assign s.rd_addr = rd_addr;
    assign s.wr_addr = wr_addr;
    assign s.wr_data = wr_data;
    assign s.wr_be   = wr_be;
    assign m0.rd_gnt = s.rd_gnt & (rd_sel == MST0) & m0.rd_req;
    assign m1.rd_gnt = s.rd_gnt & (rd_sel == MST1) & m1.rd_req;
    assign m0.wr_gnt = s.wr_gnt & (wr_sel == MST0) & m0.wr_req;
    assign m1.wr_gnt = s.wr_gnt & (wr_sel == MST1) & m1.wr_req;
    always_ff @(posedge clk) begin
        rd_own_v <= rst ? 1'b0 : s.rd_req & s.rd_gnt;
        rd_own   <= rst ? MST0 : rd_sel;
    end
    assign m0.rd_data = (rd_own_v && rd_own == MST0) ? s.rd_data : '0;
    assign m1.rd_data = (rd_own_v && rd_own == MST1) ? s.rd_data : '0;
endmodule

// File: tb/tb_naive_bus_arbiter2.sv
// tb_naive_bus_arbiter2: directed vectors plus randomized traffic against a RAM slave and a
// request-level model of the arbitration rules.
module tb_naive_bus_arbiter2;
    import naive_bus_pkg::*;
`ifdef NAIVE_ARB_FIXED_PRIO_EN
    localparam bit FIX = 1'b1;
`else
    localparam bit FIX = 1'b0;
`endif
    localparam logic [31:0] A = 32'hAAAA5555, B = 32'h12345678;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    naive_bus #(.AW(32), .DW(32)) m0_if ();
    naive_bus #(.AW(32), .DW(32)) m1_if ();
    naive_bus #(.AW(32), .DW(32)) s_if ();
    naive_bus_arbiter2 #(.AW(32), .DW(32)) dut (.clk(clk), .rst(rst), .m0(m0_if), .m1(m1_if), .s(s_if));
    logic rd_rdy = 1'b1, wr_rdy = 1'b1, clr = 1'b1, pl_en = 1'b0;
    logic [31:0] pl_a = '0, pl_d = '0;
    logic [31:0] mem [0:1023];
    assign s_if.rd_gnt = s_if.rd_req & rd_rdy;
    assign s_if.wr_gnt = s_if.wr_req & wr_rdy;
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
        end else begin
            if (pl_en) mem[pl_a[11:2]] <= pl_d;
            if (s_if.wr_req & s_if.wr_gnt)
                for (int b = 0; b < 4; b++)
                    if (s_if.wr_be[b]) mem[s_if.wr_addr[11:2]][b*8 +: 8] <= s_if.wr_data[b*8 +: 8];
        end
        s_if.rd_data <= (s_if.rd_req & s_if.rd_gnt) ? mem[s_if.rd_addr[11:2]] : 32'hFFFF_FFFF;
    end

    int total = 0, bad = 0;
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask
    task automatic idle();
        m0_if.rd_req = 0; m1_if.rd_req = 0; m0_if.wr_req = 0; m1_if.wr_req = 0;
        m0_if.wr_addr = 32'h55; m0_if.wr_data = 32'h66; m0_if.wr_be = 4'hF;
        m1_if.wr_addr = 32'h77; m1_if.wr_data = 32'h88; m1_if.wr_be = 4'hF;
    endtask
    task automatic do_reset();
        @(negedge clk); idle(); rst = 1;
        @(negedge clk); rst = 0;
    endtask

    typedef struct {logic r0, r1, rdy, g0, g1; logic [31:0] d0, d1;} vec_t;
    vec_t vec [11];
    logic rp [2], wp [2];
    logic [31:0] ra [2], wa [2], wd [2], mm [0:7], pd;
    logic [3:0] wb [2];
    logic pv, act, wact;
    int rd_last, wr_last, rw, ww, pk;

    initial begin
        vec[0]  = '{1, 1, 1, 1, 0, 0, 0};
        vec[1]  = '{1, 1, 1, FIX, !FIX, A, 0};
        vec[2]  = '{1, 1, 1, 1, 0, FIX ? A : 32'h0, FIX ? 32'h0 : B};
        vec[3]  = '{1, 1, 1, FIX, !FIX, A, 0};
        vec[4]  = '{0, 0, 1, 0, 0, FIX ? A : 32'h0, FIX ? 32'h0 : B};
        vec[5]  = '{0, 1, 0, 0, 0, 0, 0};
        vec[6]  = '{1, 1, 0, 0, 0, 0, 0};
        vec[7]  = '{1, 1, 1, 1, 0, 0, 0};
        vec[8]  = '{0, 1, 1, 0, 1, A, 0};
        vec[9]  = '{1, 0, 1, 1, 0, 0, B};
        vec[10] = '{0, 0, 1, 0, 0, A, 0};
        idle();
        m0_if.rd_addr = 32'h10; m1_if.rd_addr = 32'h20;
        @(negedge clk);
        clr = 0; pl_en = 1; pl_a = 32'h10; pl_d = A;
        m0_if.rd_req = 1; m1_if.rd_req = 1;
        #1;
        chk("rst_gnt", {m1_if.rd_gnt, m0_if.rd_gnt}, 2'b01);
        chk("rst_data", {m1_if.rd_data[15:0], m0_if.rd_data[15:0]}, 0);
        @(negedge clk);
        pl_a = 32'h20; pl_d = B;
        @(negedge clk);
        rst = 0; pl_en = 0;
        for (int i = 0; i < 11; i++) begin
            if (i > 0) @(negedge clk);
            m0_if.rd_req = vec[i].r0; m1_if.rd_req = vec[i].r1; rd_rdy = vec[i].rdy;
            #1;
            chk($sformatf("vec%0d_gnt", i), {m1_if.rd_gnt, m0_if.rd_gnt}, {vec[i].g1, vec[i].g0});
            chk($sformatf("vec%0d_d0", i), m0_if.rd_data, vec[i].d0);
            chk($sformatf("vec%0d_d1", i), m1_if.rd_data, vec[i].d1);
            if (!vec[i].r0 && !vec[i].r1) begin
                chk("idle_rd_addr", s_if.rd_addr, 0);
                chk("idle_wr", s_if.wr_addr | s_if.wr_data | {28'h0, s_if.wr_be}, 0);
            end
        end
        @(negedge clk);
        m0_if.wr_req = 1; m0_if.wr_addr = 32'h40; m0_if.wr_data = 32'hDEADBEEF; m0_if.wr_be = 4'b0011;
        m1_if.rd_req = 1; m1_if.rd_addr = 32'h44;
        #1;
        chk("conc_gnt", {m1_if.wr_gnt, m0_if.wr_gnt, m1_if.rd_gnt, m0_if.rd_gnt}, 4'b0110);
        chk("conc_s", {s_if.wr_be, s_if.wr_addr[7:0], s_if.rd_addr[7:0]}, {4'b0011, 8'h40, 8'h44});
        @(negedge clk);
        idle(); m0_if.rd_req = 1; m0_if.rd_addr = 32'h40;
        #1;
        chk("conc_rd44", m1_if.rd_data, 0);
        @(negedge clk);
        m0_if.rd_req = 0;
        #1;
        chk("conc_rd40", m0_if.rd_data, 32'h0000BEEF);
        do_reset();
        m0_if.wr_req = 1; m0_if.wr_addr = 32'h80; m0_if.wr_data = 1; m0_if.wr_be = 4'hF;
        m1_if.wr_req = 1; m1_if.wr_addr = 32'h80; m1_if.wr_data = 2; m1_if.wr_be = 4'hF;
        #1;
        chk("wc_first", {m1_if.wr_gnt, m0_if.wr_gnt, s_if.wr_data[1:0]}, 4'b0101);
        @(negedge clk);
        m0_if.wr_req = 0;
        #1;
        chk("wc_second", {m1_if.wr_gnt, m0_if.wr_gnt, s_if.wr_data[1:0]}, 4'b1010);
        @(negedge clk);
        m1_if.wr_req = 0; m0_if.rd_req = 1; m0_if.rd_addr = 32'h80;
        @(negedge clk);
        m0_if.rd_req = 1; m0_if.rd_addr = 32'h10;
        #1;
        chk("wc_final", m0_if.rd_data, 2);
        @(negedge clk);
        m0_if.rd_req = 0; m1_if.rd_req = 1; m1_if.rd_addr = 32'h20;
        m0_if.wr_req = 1; m0_if.wr_addr = 32'h84; m0_if.wr_data = 7;
        rst = 1;
        #1;
        chk("mr_gnt", {m1_if.rd_gnt, m0_if.wr_gnt}, 2'b11);
        @(negedge clk);
        rst = 0; idle();
        #1;
        chk("mr_drop", {m1_if.rd_data, m0_if.rd_data[0]}, 0);
        @(negedge clk);
        m0_if.rd_req = 1; m1_if.rd_req = 1; m0_if.wr_req = 1; m1_if.wr_req = 1;
        #1;
        chk("mr_ptr", {m1_if.rd_gnt, m0_if.rd_gnt, m1_if.wr_gnt, m0_if.wr_gnt}, 4'b0101);
        do_reset();
        rd_last = 1; wr_last = 1; pv = 0; pk = 0; pd = 0;
        for (int i = 0; i < 8; i++) mm[i] = '0;
        for (int k = 0; k < 2; k++) begin rp[k] = 0; wp[k] = 0; end
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!rp[k] && $urandom_range(0, 1) == 1) begin
                    rp[k] = 1; ra[k] = 32'h200 + 4 * $urandom_range(0, 7);
                end
                if (!wp[k] && $urandom_range(0, 1) == 1) begin
                    wp[k] = 1; wa[k] = 32'h200 + 4 * $urandom_range(0, 7);
                    wd[k] = $urandom; wb[k] = 4'($urandom_range(1, 15));
                end
            end
            m0_if.rd_req = rp[0]; m0_if.rd_addr = rp[0] ? ra[0] : $urandom;
            m1_if.rd_req = rp[1]; m1_if.rd_addr = rp[1] ? ra[1] : $urandom;
            m0_if.wr_req = wp[0]; m0_if.wr_addr = wp[0] ? wa[0] : $urandom;
            m1_if.wr_req = wp[1]; m1_if.wr_addr = wp[1] ? wa[1] : $urandom;
            m0_if.wr_data = wd[0]; m0_if.wr_be = wb[0];
            m1_if.wr_data = wd[1]; m1_if.wr_be = wb[1];
            rd_rdy = $urandom_range(0, 3) != 0; wr_rdy = $urandom_range(0, 3) != 0;
            #1;
            rw = (rp[0] && rp[1]) ? (FIX ? 0 : 1 - rd_last) : (rp[1] ? 1 : 0);
            ww = (wp[0] && wp[1]) ? (FIX ? 0 : 1 - wr_last) : (wp[1] ? 1 : 0);
            act = rd_rdy && (rp[0] || rp[1]);
            wact = wr_rdy && (wp[0] || wp[1]);
            chk("rnd_rd_gnt", {m1_if.rd_gnt, m0_if.rd_gnt}, act ? (rw == 0 ? 2'b01 : 2'b10) : 2'b00);
            chk("rnd_wr_gnt", {m1_if.wr_gnt, m0_if.wr_gnt}, wact ? (ww == 0 ? 2'b01 : 2'b10) : 2'b00);
            chk("rnd_d0", m0_if.rd_data, (pv && pk == 0) ? pd : 32'h0);
            chk("rnd_d1", m1_if.rd_data, (pv && pk == 1) ? pd : 32'h0);
            if (!rp[0] && !rp[1]) chk("rnd_idle_rd", s_if.rd_addr, 0);
            if (wact) begin
                chk("rnd_wr_addr", s_if.wr_addr, wa[ww]);
                chk("rnd_wr_data", s_if.wr_data, wd[ww]);
                chk("rnd_wr_be", {28'h0, s_if.wr_be}, {28'h0, wb[ww]});
            end
            pv = act;
            if (act) begin
                pk = rw; pd = mm[(ra[rw] - 32'h200) >> 2]; rd_last = rw; rp[rw] = 0;
            end
            if (wact) begin
                for (int b = 0; b < 4; b++)
                    if (wb[ww][b]) mm[(wa[ww] - 32'h200) >> 2][b*8 +: 8] = wd[ww][b*8 +: 8];
                wr_last = ww; wp[ww] = 0;
            end
        end
        @(negedge clk);
        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
